// File: rtl/hawk_zspg_cpage_alloc_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hawk_zspg_cpage_alloc_if                                      |
// | Purpose  : Bundles the request, metadata read, metadata write-back and   |
// |            response handshakes of the cpage allocator.                   |
// | Ports    : slave  - allocator side (requests in, results out)            |
// |            master - requester / AXI read-write master side               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface hawk_zspg_cpage_alloc_if #(
  parameter int ADDR_W = 48,
  parameter int DATA_W = 512
);
  // request channel from the compression manager
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_op_i;
  logic [ADDR_W-1:0] req_md_addr_i;
  logic [ADDR_W-1:0] req_cpage_i;
  // metadata read channel
  logic              rd_req_valid_o;
  logic              rd_req_ready_i;
  logic [ADDR_W-1:0] rd_req_addr_o;
  logic              rd_rsp_valid_i;
  logic              rd_rsp_ready_o;
  logic [DATA_W-1:0] rd_rsp_data_i;
  // metadata write-back channel
  logic              wr_req_valid_o;
  logic              wr_req_ready_i;
  logic [ADDR_W-1:0] wr_req_addr_o;
  logic [DATA_W-1:0] wr_req_data_o;
  logic              wr_ack_i;
  // result channel
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [1:0]        rsp_status_o;
  logic [ADDR_W-1:0] rsp_cpage_o;

  modport slave (
    input  req_valid_i, req_op_i, req_md_addr_i, req_cpage_i,
           rd_req_ready_i, rd_rsp_valid_i, rd_rsp_data_i,
           wr_req_ready_i, wr_ack_i, rsp_ready_i,
    output req_ready_o, rd_req_valid_o, rd_req_addr_o, rd_rsp_ready_o,
           wr_req_valid_o, wr_req_addr_o, wr_req_data_o,
           rsp_valid_o, rsp_status_o, rsp_cpage_o
  );

  modport master (
    output req_valid_i, req_op_i, req_md_addr_i, req_cpage_i,
           rd_req_ready_i, rd_rsp_valid_i, rd_rsp_data_i,
           wr_req_ready_i, wr_ack_i, rsp_ready_i,
    input  req_ready_o, rd_req_valid_o, rd_req_addr_o, rd_rsp_ready_o,
           wr_req_valid_o, wr_req_addr_o, wr_req_data_o,
           rsp_valid_o, rsp_status_o, rsp_cpage_o
  );
endinterface
`default_nettype wire

// File: rtl/hawk_zspg_cpage_alloc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hawk_zspg_cpage_alloc                                         |
// | Purpose  : Allocates / frees compressed-page slots inside a ZsPage way.  |
// |            Reads the 64B metadata line, finds or validates a slot in    |
// |            the used bitmap, writes the updated line back and returns    |
// |            the cpage byte address.                                       |
// | Ports    : clk_i  - clock                                                |
// |            rst_ni - asynchronous active-low reset                        |
// |            bus    - request / md read / md write / response handshakes   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hawk_zspg_cpage_alloc #(
  parameter int ADDR_W                = 48,
  parameter int DATA_W                = 512,
  parameter int NUM_PG                = 16,
  parameter int NUM_SIZES             = 4,
  parameter int CSIZE_LOG2[NUM_SIZES] = '{6, 7, 8, 9},
  parameter int ZS_OFFSET             = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  hawk_zspg_cpage_alloc_if.slave bus
);

  // metadata line field positions
  localparam int c_SIZE_LSB = 96;
  localparam int c_USED_LSB = 104;

  localparam logic       c_OP_ALLOC = 1'b0;
  localparam logic [1:0] c_ST_OK    = 2'b00;
  localparam logic [1:0] c_ST_FULL  = 2'b01;
  localparam logic [1:0] c_ST_ERR   = 2'b10;

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_RD_REQ  = 3'd1;
  localparam logic [2:0] c_RD_WAIT = 3'd2;
  localparam logic [2:0] c_CALC    = 3'd3;
  localparam logic [2:0] c_WR_REQ  = 3'd4;
  localparam logic [2:0] c_WR_ACK  = 3'd5;
  localparam logic [2:0] c_RSP     = 3'd6;

  logic [2:0]        r_state;
  logic              r_op;
  logic [ADDR_W-1:0] r_md_addr;
  logic [ADDR_W-1:0] r_cpage;
  logic [DATA_W-1:0] r_line;
  logic [DATA_W-1:0] r_wr_data;
  logic [1:0]        r_status;
  logic [ADDR_W-1:0] r_rsp_cpage;

  // ---------------------------------------------------------------- decode
  logic [ADDR_W-1:0] w_iway;
  logic [7:0]        w_size_idx;
  logic [NUM_PG-1:0] w_used;
  logic [5:0]        w_sz;
  logic              w_size_ok;

  assign w_iway     = ADDR_W'(r_line[47:0]);
  assign w_size_idx = r_line[c_SIZE_LSB +: 8];
  assign w_used     = r_line[c_USED_LSB +: NUM_PG];

  // table lookup by compare so an out-of-range size_idx never indexes the table
  always_comb begin
    w_sz      = 6'd0;
    w_size_ok = 1'b0;
    for (int i = 0; i < NUM_SIZES; i++) begin
      if (w_size_idx == 8'(i)) begin
        w_sz      = 6'(CSIZE_LOG2[i]);
        w_size_ok = 1'b1;
      end
    end
  end

  // a slot is legal only if it ends inside the 4KB page
  logic [NUM_PG-1:0] w_legal;
  for (genvar k = 0; k < NUM_PG; k++) begin : g_legal
    assign w_legal[k] = (64'(ZS_OFFSET) + (64'(k + 1) << w_sz)) <= 64'd4096;
  end

  // ---------------------------------------------------------------- alloc
  logic              w_alloc_found;
  logic [6:0]        w_alloc_slot;
  logic [ADDR_W-1:0] w_alloc_addr;

  // descending scan so the lowest free legal slot wins
  always_comb begin
    w_alloc_found = 1'b0;
    w_alloc_slot  = 7'd0;
    for (int k = NUM_PG - 1; k >= 0; k--) begin
      if (w_legal[k] && !w_used[k]) begin
        w_alloc_found = 1'b1;
        w_alloc_slot  = 7'(k);
      end
    end
  end

  assign w_alloc_addr = w_iway + ADDR_W'(ZS_OFFSET) + (ADDR_W'(w_alloc_slot) << w_sz);

  // ---------------------------------------------------------------- free
  logic [ADDR_W:0]   w_base;
  logic              w_below;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_mask;
  logic              w_misalign;
  logic [ADDR_W-1:0] w_koff;
  logic              w_free_legal;
  logic              w_free_used;

  // base kept one bit wider so the below-base test is exact near the top
  assign w_base     = {1'b0, w_iway} + (ADDR_W+1)'(ZS_OFFSET);
  assign w_below    = {1'b0, r_cpage} < w_base;
  assign w_off      = r_cpage - w_base[ADDR_W-1:0];
  assign w_mask     = (ADDR_W'(1) << w_sz) - ADDR_W'(1);
  assign w_misalign = |(w_off & w_mask);
  assign w_koff     = w_off >> w_sz;

  always_comb begin
    w_free_legal = 1'b0;
    w_free_used  = 1'b0;
    for (int k = 0; k < NUM_PG; k++) begin
      if (w_koff == ADDR_W'(k)) begin
        w_free_legal = w_legal[k];
        w_free_used  = w_used[k];
      end
    end
  end

  // ---------------------------------------------------------------- result
  logic [NUM_PG-1:0] w_new_used;
  logic [DATA_W-1:0] w_new_line;
  logic [1:0]        w_status;
  logic [ADDR_W-1:0] w_rsp_cpage;

  always_comb begin
    w_new_used = w_used;
    for (int k = 0; k < NUM_PG; k++) begin
      if (r_op == c_OP_ALLOC) begin
        if (w_alloc_slot == 7'(k)) w_new_used[k] = 1'b1;
      end else if (w_koff == ADDR_W'(k)) begin
        w_new_used[k] = 1'b0;
      end
    end
  end

  always_comb begin
    w_new_line = r_line;
    w_new_line[c_USED_LSB +: NUM_PG] = w_new_used;
  end

  always_comb begin
    w_status    = c_ST_ERR;
    w_rsp_cpage = '0;
    if (w_size_ok) begin
      if (r_op == c_OP_ALLOC) begin
        if (w_alloc_found) begin
          w_status    = c_ST_OK;
          w_rsp_cpage = w_alloc_addr;
        end else begin
          w_status    = c_ST_FULL;
        end
      end else if (!w_below && !w_misalign && w_free_legal && w_free_used) begin
        w_status    = c_ST_OK;
        w_rsp_cpage = r_cpage;
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= c_IDLE;
      r_op        <= 1'b0;
      r_md_addr   <= '0;
      r_cpage     <= '0;
      r_line      <= '0;
      r_wr_data   <= '0;
      r_status    <= 2'b00;
      r_rsp_cpage <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.req_valid_i) begin
            r_op        <= bus.req_op_i;
            r_md_addr   <= bus.req_md_addr_i;
            r_cpage     <= bus.req_cpage_i;
            r_status    <= 2'b00;
            r_rsp_cpage <= '0;
            r_state     <= c_RD_REQ;
          end
        end
        c_RD_REQ: begin
          if (bus.rd_req_ready_i) r_state <= c_RD_WAIT;
        end
        c_RD_WAIT: begin
          if (bus.rd_rsp_valid_i) begin
            r_line  <= bus.rd_rsp_data_i;
            r_state <= c_CALC;
          end
        end
        c_CALC: begin
          r_status    <= w_status;
          r_rsp_cpage <= w_rsp_cpage;
          r_wr_data   <= w_new_line;
          r_state     <= (w_status == c_ST_OK) ? c_WR_REQ : c_RSP;
        end
        c_WR_REQ: begin
          if (bus.wr_req_ready_i) r_state <= c_WR_ACK;
        end
        c_WR_ACK: begin
          if (bus.wr_ack_i) r_state <= c_RSP;
        end
        c_RSP: begin
          if (bus.rsp_ready_i) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // all handshake outputs decode straight from registered state
  assign bus.req_ready_o    = (r_state == c_IDLE);
  assign bus.rd_req_valid_o = (r_state == c_RD_REQ);
  assign bus.rd_req_addr_o  = r_md_addr;
  assign bus.rd_rsp_ready_o = (r_state == c_RD_WAIT);
  assign bus.wr_req_valid_o = (r_state == c_WR_REQ);
  assign bus.wr_req_addr_o  = r_md_addr;
  assign bus.wr_req_data_o  = r_wr_data;
  assign bus.rsp_valid_o    = (r_state == c_RSP);
  assign bus.rsp_status_o   = r_status;
  assign bus.rsp_cpage_o    = r_rsp_cpage;

endmodule
`default_nettype wire
